branch_ctrl: RTL

- Sequences branch resolution in the ID stage of the 5-stage MIPS pipeline.
- Detects RAW hazards on branch operands against instructions still in EXE/MEM, and stalls ID until they clear.
- Evaluates the branch condition, then emits a registered one-cycle taken/flush pulse plus target address to IF.
- Sits between ID-stage decode and IF-stage PC mux/flush logic.

---
 rtl/branch_ctrl_pkg.sv | 6 +
 rtl/br_cond_eval.sv | 15 +
 rtl/branch_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared branch-type encodings, FSM states and constants for branch_ctrl
package branch_ctrl_pkg;
  typedef enum logic [1:0] {BR_NONE = 2'b00, BR_BEQ = 2'b01, BR_BNE = 2'b10, BR_JMP = 2'b11} br_type_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_FLUSH = 2'd2} state_e;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: combinational branch condition (BEQ/BNE full-width compare, JMP always taken)
module br_cond_eval
  import branch_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        br_type,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] src2_val,
  output logic              taken
);
  // Unsigned equality is all BEQ/BNE need; type 00 never takes
  always_comb taken = (br_type == BR_JMP) || (br_type == BR_BEQ && val1 == src2_val) ||
                      (br_type == BR_BNE && val1 != src2_val);
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch resolution with RAW stall and registered taken/flush pulse; BRANCH_CTRL_STATS_EN adds 16-bit statistics counters
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [1:0]             br_type,
  input  logic [DATA_W-1:0]      val1,
  input  logic [DATA_W-1:0]      src2_val,
  input  logic [REG_AW-1:0]      src1_addr,
  input  logic [REG_AW-1:0]      src2_addr,
  input  logic [DATA_W-1:0]      br_target,
  input  logic                   exe_wb_en,
  input  logic [REG_AW-1:0]      exe_dest,
  input  logic                   mem_wb_en,
  input  logic [REG_AW-1:0]      mem_dest,
  output logic                   stall_id,
  output logic                   br_taken,
  output logic                   flush_if,
  output logic [DATA_W-1:0]      br_addr,
  output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [15:0]            stat_taken,
  output logic [15:0]            stat_not_taken,
  output logic [15:0]            stat_stall
`endif
);
  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        br_addr_q, br_addr_d;
  logic [STALL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                     is_br, haz1, haz2, hazard, taken, stall_raw, res_taken, res_not;
  br_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .br_type (br_type),
    .val1    (val1),
    .src2_val(src2_val),
    .taken   (taken)
  );
  // Operand hazards against EXE/MEM writers; r0 and jumps never stall
  always_comb begin
    is_br  = id_valid && br_type != BR_NONE;
    haz1   = src1_addr != REG_AW'(REG_ZERO) &&
             ((exe_wb_en && exe_dest == src1_addr) || (mem_wb_en && mem_dest == src1_addr));
    haz2   = src2_addr != REG_AW'(REG_ZERO) &&
             ((exe_wb_en && exe_dest == src2_addr) || (mem_wb_en && mem_dest == src2_addr));
    hazard = (br_type == BR_BEQ || br_type == BR_BNE) && (haz1 || haz2);
  end
  // IDLE and WAIT share resolve logic; they differ only in how the stall counter moves
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    br_addr_d = br_addr_q;
    stall_raw = 1'b0;
    res_taken = 1'b0;
    res_not   = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (!is_br) begin
          state_d = ST_IDLE;
        end else if (hazard) begin
          stall_raw = 1'b1;
          state_d   = ST_WAIT;
          cnt_d     = (state_q == ST_IDLE) ? STALL_CNT_W'(1) :
                      (&cnt_q) ? cnt_q : cnt_q + STALL_CNT_W'(1);
        end else begin
          res_taken = taken;
          res_not   = !taken;
          state_d   = taken ? ST_FLUSH : ST_IDLE;
          br_addr_d = taken ? br_target : br_addr_q;
          cnt_d     = (state_q == ST_IDLE) ? '0 : cnt_q;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // State, target and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      br_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      br_addr_q <= br_addr_d;
      cnt_q     <= cnt_d;
    end
  end
  // Stall must vanish the instant reset asserts, even with hazard inputs still present
  assign stall_id  = rst_n && stall_raw;
  assign br_taken  = state_q == ST_FLUSH;
  assign flush_if  = state_q == ST_FLUSH;
  assign br_addr   = br_addr_q;
  assign stall_cnt = cnt_q;
`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0] st_taken_q, st_not_q, st_stall_q;
  // Saturating resolve and stall statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_taken_q <= '0;
      st_not_q   <= '0;
      st_stall_q <= '0;
    end else begin
      st_taken_q <= st_taken_q + 16'((res_taken && !(&st_taken_q)) ? 1 : 0);
      st_not_q   <= st_not_q + 16'((res_not && !(&st_not_q)) ? 1 : 0);
      st_stall_q <= st_stall_q + 16'((stall_raw && !(&st_stall_q)) ? 1 : 0);
    end
  end
  assign stat_taken     = st_taken_q;
  assign stat_not_taken = st_not_q;
  assign stat_stall     = st_stall_q;
`endif
endmodule
